// File: rtl/vram_scanout_pkg.sv
// Shared types and constants for the VRAM video-port scanout path.
package vram_scanout_pkg;

    typedef logic [23:0] rgb_t;
    typedef rgb_t [15:0] palette_t;

    typedef struct packed {
        int unsigned active;
        int unsigned fp;
        int unsigned sync;
        int unsigned bp;
    } timing_t;

    // Control bits travelling alongside the VRAM read through the pipeline
    typedef struct packed {
        logic img;
        logic sel;
        logic de;
        logic hs;
        logic vs;
        logic fs;
    } pipe_t;

    // CGA 16-colour palette, entry 0 in the LSBs
    localparam palette_t DEFAULT_PALETTE = {
        24'hFFFFFF, 24'hFFFF55, 24'hFF55FF, 24'hFF5555,
        24'h55FFFF, 24'h55FF55, 24'h5555FF, 24'h555555,
        24'hAAAAAA, 24'hAA5500, 24'hAA00AA, 24'hAA0000,
        24'h00AAAA, 24'h00AA00, 24'h0000AA, 24'h000000
    };

    function automatic int unsigned total(timing_t t);
        return t.active + t.fp + t.sync + t.bp;
    endfunction

    // Counter width able to hold 0..n-1, never below one bit
    function automatic int unsigned cnt_w(int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster position counters with active/sync/frame-start decode for one h/v timing pair.
module vga_timing_gen
    import vram_scanout_pkg::*;
#(
    parameter timing_t     H_T = '{active: 640, fp: 16, sync: 96, bp: 48},
    parameter timing_t     V_T = '{active: 480, fp: 10, sync: 2, bp: 33},
    parameter int unsigned HW  = cnt_w(total(H_T)),
    parameter int unsigned VW  = cnt_w(total(V_T))
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          de_c,
    output logic          hs_c,
    output logic          vs_c,
    output logic          fs_c,
    output logic          line_end_c
);

    localparam int unsigned H_LAST   = total(H_T) - 1;
    localparam int unsigned V_LAST   = total(V_T) - 1;
    localparam int unsigned HS_START = H_T.active + H_T.fp;
    localparam int unsigned HS_END   = HS_START + H_T.sync;
    localparam int unsigned VS_START = V_T.active + V_T.fp;
    localparam int unsigned VS_END   = VS_START + V_T.sync;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            h <= '0;
            v <= '0;
        end else if (line_end_c) begin
            h <= '0;
            v <= (32'(v) == V_LAST) ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

    // Each axis runs active, front porch, sync, back porch
    assign line_end_c = (32'(h) == H_LAST);
    assign de_c       = (32'(h) < H_T.active) && (32'(v) < V_T.active);
    assign hs_c       = (32'(h) >= HS_START) && (32'(h) < HS_END);
    assign vs_c       = (32'(v) >= VS_START) && (32'(v) < VS_END);
    assign fs_c       = (h == '0) && (v == '0);

endmodule

// File: rtl/vram_scanout.sv
// 16-colour VRAM scanout: raster timing, nibble fetch, palette lookup to RGB888 + syncs.
// Optional writable palette when VRAM_SCANOUT_PALETTE_EN is defined.
module vram_scanout
    import vram_scanout_pkg::*;
#(
    parameter int unsigned WIDTH      = 128,
    parameter int unsigned HEIGHT     = 128,
    parameter int unsigned SCALE      = 3,
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 33,
    parameter int unsigned H_OFFSET   = 128,
    parameter int unsigned V_OFFSET   = 48,
    parameter bit          HS_POL     = 1'b0,
    parameter bit          VS_POL     = 1'b0,
    parameter rgb_t        BORDER_RGB = 24'h000000,
    parameter int unsigned ADDR_W     = $clog2((WIDTH * HEIGHT + 1) >> 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    output logic              o_mev,
    output logic [ADDR_W-1:0] o_adrv,
    input  logic [7:0]        i_qv,
    output logic [23:0]       o_rgb,
    output logic              o_de,
    output logic              o_hsync,
    output logic              o_vsync,
    output logic              o_frame_start
`ifdef VRAM_SCANOUT_PALETTE_EN
    ,
    input  logic              i_pal_we,
    input  logic [3:0]        i_pal_idx,
    input  logic [23:0]       i_pal_rgb
`endif
);

    localparam timing_t     H_T       = '{active: H_ACTIVE, fp: H_FP, sync: H_SYNC, bp: H_BP};
    localparam timing_t     V_T       = '{active: V_ACTIVE, fp: V_FP, sync: V_SYNC, bp: V_BP};
    localparam int unsigned HW        = cnt_w(total(H_T));
    localparam int unsigned VW        = cnt_w(total(V_T));
    localparam int unsigned PIX_W     = cnt_w(WIDTH * HEIGHT + 1);
    localparam int unsigned SX_W      = cnt_w(WIDTH + 1);
    localparam int unsigned SUB_W     = cnt_w(SCALE);
    localparam int unsigned H_IMG_END = H_OFFSET + WIDTH * SCALE;
    localparam int unsigned V_IMG_END = V_OFFSET + HEIGHT * SCALE;

    logic [HW-1:0]    h;
    logic [VW-1:0]    v;
    logic             de_c;
    logic             hs_c;
    logic             vs_c;
    logic             fs_c;
    logic             line_end_c;
    logic             h_in_c;
    logic             v_in_c;
    logic             en_eff_c;
    logic             img_c;
    logic [PIX_W-1:0] pix_c;
    logic [3:0]       nib_c;

    logic             en_latch;
    logic [SX_W-1:0]  sx;
    logic [SUB_W-1:0] sub_x;
    logic [SUB_W-1:0] sub_y;
    logic [PIX_W-1:0] row_base;
    pipe_t            s1;
    pipe_t            s2;
    palette_t         pal;

    vga_timing_gen #(
        .H_T (H_T),
        .V_T (V_T),
        .HW  (HW),
        .VW  (VW)
    ) u_timing (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .h          (h),
        .v          (v),
        .de_c       (de_c),
        .hs_c       (hs_c),
        .vs_c       (vs_c),
        .fs_c       (fs_c),
        .line_end_c (line_end_c)
    );

    // Enable applies from the first pixel of the frame in which it is sampled
    assign en_eff_c = fs_c ? i_enable : en_latch;
    assign h_in_c   = (32'(h) >= H_OFFSET) && (32'(h) < H_IMG_END);
    assign v_in_c   = (32'(v) >= V_OFFSET) && (32'(v) < V_IMG_END);
    assign img_c    = de_c && h_in_c && v_in_c && en_eff_c;
    assign pix_c    = row_base + PIX_W'(sx);

    // Source coordinate tracking by replication sub-counters
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            en_latch <= 1'b0;
            sx       <= '0;
            sub_x    <= '0;
            sub_y    <= '0;
            row_base <= '0;
        end else begin
            if (fs_c) begin
                en_latch <= i_enable;
            end
            if (h_in_c && !line_end_c) begin
                if (32'(sub_x) == SCALE - 1) begin
                    sub_x <= '0;
                    sx    <= sx + SX_W'(1);
                end else begin
                    sub_x <= sub_x + SUB_W'(1);
                end
            end else begin
                sub_x <= '0;
                sx    <= '0;
            end
            if (line_end_c) begin
                if (v_in_c) begin
                    if (32'(sub_y) == SCALE - 1) begin
                        sub_y    <= '0;
                        row_base <= row_base + PIX_W'(WIDTH);
                    end else begin
                        sub_y <= sub_y + SUB_W'(1);
                    end
                end else begin
                    sub_y    <= '0;
                    row_base <= '0;
                end
            end
        end
    end

`ifdef VRAM_SCANOUT_PALETTE_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pal <= DEFAULT_PALETTE;
        end else if (i_pal_we) begin
            pal[i_pal_idx] <= i_pal_rgb;
        end
    end
`else
    assign pal = DEFAULT_PALETTE;
`endif

    assign nib_c = s2.sel ? i_qv[7:4] : i_qv[3:0];

    // Address issue, VRAM return and palette output stages
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_mev         <= 1'b0;
            o_adrv        <= '0;
            s1            <= '0;
            s2            <= '0;
            o_rgb         <= '0;
            o_de          <= 1'b0;
            o_hsync       <= !HS_POL;
            o_vsync       <= !VS_POL;
            o_frame_start <= 1'b0;
        end else begin
            o_mev <= img_c;
            if (img_c) begin
                o_adrv <= ADDR_W'(pix_c >> 1);
            end
            s1 <= '{img: img_c, sel: pix_c[0], de: de_c, hs: hs_c, vs: vs_c, fs: fs_c};
            s2 <= s1;
            if (s2.img) begin
                o_rgb <= pal[nib_c];
            end else if (s2.de) begin
                o_rgb <= BORDER_RGB;
            end else begin
                o_rgb <= '0;
            end
            o_de          <= s2.de;
            o_hsync       <= s2.hs ? HS_POL : !HS_POL;
            o_vsync       <= s2.vs ? VS_POL : !VS_POL;
            o_frame_start <= s2.fs;
        end
    end

endmodule

// File: tb/tb_vram_scanout.sv
// Scoreboard bench for vram_scanout on a reduced raster; reference computed per pixel from raster rules.
module tb_vram_scanout;

    localparam int unsigned W = 8, H = 6, S = 2;
    localparam int unsigned HA = 32, HFP = 4, HSY = 6, HBP = 6;
    localparam int unsigned VA = 20, VFP = 2, VSY = 2, VBP = 3;
    localparam int unsigned HT = HA + HFP + HSY + HBP;
    localparam int unsigned VT = VA + VFP + VSY + VBP;
    localparam int unsigned FRAME = HT * VT;
    localparam int unsigned HOFF = 20, VOFF = 4;
    localparam bit HPOL = 1'b0, VPOL = 1'b1;
    localparam logic [23:0] BORDER = 24'h123456;
    localparam int unsigned NBYTES = (W * H) / 2;
    localparam int unsigned AW = $clog2((W * H + 1) >> 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          mev;
    logic [AW-1:0] adrv;
    logic [7:0]    qv = 8'h00;
    logic [23:0]   rgb;
    logic          de, hsync, vsync, frame_start;
`ifdef VRAM_SCANOUT_PALETTE_EN
    logic          pal_we = 1'b0;
    logic [3:0]    pal_idx = 4'h0;
    logic [23:0]   pal_rgb = 24'h0;
`endif

    vram_scanout #(
        .WIDTH(W), .HEIGHT(H), .SCALE(S),
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .H_OFFSET(HOFF), .V_OFFSET(VOFF),
        .HS_POL(HPOL), .VS_POL(VPOL), .BORDER_RGB(BORDER)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_enable(enable),
        .o_mev(mev), .o_adrv(adrv), .i_qv(qv),
        .o_rgb(rgb), .o_de(de), .o_hsync(hsync), .o_vsync(vsync),
        .o_frame_start(frame_start)
`ifdef VRAM_SCANOUT_PALETTE_EN
        , .i_pal_we(pal_we), .i_pal_idx(pal_idx), .i_pal_rgb(pal_rgb)
`endif
    );

    typedef struct { int t; bit de; bit hs; bit vs; bit fs; int kind; logic [3:0] nib; } exp_t;
    typedef struct { int t; bit mev; logic [AW-1:0] adr; } mexp_t;

    exp_t          exp_q[$];
    mexp_t         mev_q[$];
    logic [7:0]    vram[NBYTES];
    logic [23:0]   pal_m[16], pal_d1[16], pal_d2[16];
    int            checks = 0, errors = 0;
    bit            running = 1'b0;
    int            t = 0;
    bit            en_m = 1'b0;
    logic [AW-1:0] last_adr = '0;

    always #5 clk = ~clk;

    // VRAM video port: data one clock after the read request
    always @(posedge clk) qv <= mev ? vram[adrv] : 8'($urandom);

    // Palette as seen by the output stage (write lands one clock later, used the clock after)
    always @(posedge clk) begin
        pal_d1 <= pal_m;
        pal_d2 <= pal_d1;
    end

    function automatic logic [23:0] cga(int i);
        case (i)
            0: return 24'h000000;  1: return 24'h0000AA;  2: return 24'h00AA00;  3: return 24'h00AAAA;
            4: return 24'hAA0000;  5: return 24'hAA00AA;  6: return 24'hAA5500;  7: return 24'hAAAAAA;
            8: return 24'h555555;  9: return 24'h5555FF; 10: return 24'h55FF55; 11: return 24'h55FFFF;
           12: return 24'hFF5555; 13: return 24'hFF55FF; 14: return 24'hFFFF55;
            default: return 24'hFFFFFF;
        endcase
    endfunction

    // Expected response for the raster position of cycle t since reset release
    task automatic push_cycle();
        int h, v, p;
        bit img;
        logic [7:0] bv;
        exp_t e;
        mexp_t m;
        h = t % HT;
        v = (t / HT) % VT;
        if (h == 0 && v == 0) en_m = enable;
        e.t  = t;
        e.de = (h < HA) && (v < VA);
        e.hs = (h >= HA + HFP) && (h < HA + HFP + HSY);
        e.vs = (v >= VA + VFP) && (v < VA + VFP + VSY);
        e.fs = (h == 0) && (v == 0);
        img = e.de && en_m && h >= HOFF && h < HOFF + W * S && v >= VOFF && v < VOFF + H * S;
        e.nib = 4'h0;
        if (img) begin
            p = ((v - VOFF) / S) * W + (h - HOFF) / S;
            bv = vram[p / 2];
            e.nib = (p % 2 == 1) ? bv[7:4] : bv[3:0];
            e.kind = 2;
            last_adr = AW'(p / 2);
        end else begin
            e.kind = e.de ? 1 : 0;
        end
        m.t = t;
        m.mev = img;
        m.adr = last_adr;
        exp_q.push_back(e);
        mev_q.push_back(m);
        t++;
    endtask

    task automatic do_reset(int n);
        exp_t  ef;
        mexp_t mf;
        @(posedge clk); #1;
        rst = 1'b1;
        running = 1'b0;
        exp_q.delete();
        mev_q.delete();
`ifdef VRAM_SCANOUT_PALETTE_EN
        pal_we = 1'b0;
        for (int i = 0; i < 16; i++) pal_m[i] = cga(i);
`endif
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        t = 0;
        en_m = 1'b0;
        last_adr = '0;
        ef = '{t: -1, de: 1'b0, hs: 1'b0, vs: 1'b0, fs: 1'b0, kind: 0, nib: 4'h0};
        mf = '{t: -1, mev: 1'b0, adr: '0};
        repeat (3) exp_q.push_back(ef);
        mev_q.push_back(mf);
        running = 1'b1;
        push_cycle();
    endtask

    task automatic run_cycles(int n, int flip_rate, int pal_mode, int pal_at);
        repeat (n) begin
            @(posedge clk); #1;
            if (flip_rate > 0 && $urandom_range(0, flip_rate - 1) == 0) enable = ~enable;
`ifdef VRAM_SCANOUT_PALETTE_EN
            pal_we = 1'b0;
            if (t == pal_at) begin
                pal_we = 1'b1; pal_idx = 4'h1; pal_rgb = 24'hFF0000;
                pal_m[1] = 24'hFF0000;
            end else if (pal_mode != 0 && $urandom_range(0, 99) == 0) begin
                pal_we = 1'b1; pal_idx = 4'($urandom); pal_rgb = 24'($urandom);
                pal_m[pal_idx] = pal_rgb;
            end
`endif
            push_cycle();
        end
    endtask

    // Monitor: reset state while held, else pop one expectation per output clock
    int rcnt = 0, ncyc = 0, last_fs = -1;
    always @(negedge clk) begin
        exp_t e;
        mexp_t m;
        logic [23:0] xrgb;
        logic xhs, xvs;
        if (rst) begin
            rcnt++;
            ncyc = 0;
            last_fs = -1;
            if (rcnt >= 2) begin
                checks++;
                if (de !== 1'b0 || mev !== 1'b0 || rgb !== 24'h0 || adrv !== '0 ||
                    hsync !== !HPOL || vsync !== !VPOL || frame_start !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state: de=%b mev=%b rgb=%h adrv=%h hs=%b vs=%b fs=%b (need 0 0 000000 0 %b %b 0)",
                             de, mev, rgb, adrv, hsync, vsync, frame_start, !HPOL, !VPOL);
                end
            end
        end else begin
            rcnt = 0;
            if (running) begin
                if (exp_q.size() == 0 || mev_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_underflow: exp=%0d mev=%0d entries", exp_q.size(), mev_q.size());
                end else begin
                    e = exp_q.pop_front();
                    m = mev_q.pop_front();
                    xrgb = (e.kind == 2) ? pal_d2[e.nib] : (e.kind == 1) ? BORDER : 24'h0;
                    xhs = e.hs ? HPOL : !HPOL;
                    xvs = e.vs ? VPOL : !VPOL;
                    checks++;
                    if (de !== e.de || hsync !== xhs || vsync !== xvs || frame_start !== e.fs || rgb !== xrgb) begin
                        errors++;
                        $display("FAIL pixel t=%0d: de=%b hs=%b vs=%b fs=%b rgb=%h, required de=%b hs=%b vs=%b fs=%b rgb=%h",
                                 e.t, de, hsync, vsync, frame_start, rgb, e.de, xhs, xvs, e.fs, xrgb);
                    end
                    checks++;
                    if (mev !== m.mev || adrv !== m.adr) begin
                        errors++;
                        $display("FAIL vram_req t=%0d: mev=%b adrv=%0d, required mev=%b adrv=%0d",
                                 m.t, mev, adrv, m.mev, m.adr);
                    end
                end
                if (frame_start === 1'b1) begin
                    if (last_fs >= 0) begin
                        checks++;
                        if (ncyc - last_fs != FRAME) begin
                            errors++;
                            $display("FAIL frame_period: %0d clocks, required %0d", ncyc - last_fs, FRAME);
                        end
                    end
                    last_fs = ncyc;
                end
                ncyc++;
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) pal_m[i] = cga(i);
        for (int i = 0; i < NBYTES; i++) vram[i] = 8'($urandom);
        vram[0] = 8'h21;
        vram[4] = 8'h0F;
        enable = 1'b1;
        do_reset(5);
        run_cycles(2 * FRAME + 50, 0, 0, -1);
        enable = 1'b0;
        run_cycles(FRAME, 0, 0, -1);
        enable = 1'b1;
        run_cycles(FRAME / 2 + 7, 0, 0, -1);
        do_reset(3);
        run_cycles(2 * FRAME, 0, 0, FRAME + HT * (VOFF + 2) + HOFF + 3);
        run_cycles(3 * FRAME, 400, 1, -1);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
